// File: rtl/mac_acc_stream.sv
// Pipelined multiply-accumulate with valid/ready streaming, per-frame result dump,
// and registered rounding / shift / saturation of the frame sum.
module mac_acc_stream #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 2*(DATA_W+DATA_W/2),
    parameter int unsigned OUT_W   = DATA_W,
    parameter int unsigned SHIFT_W = 6,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               MAC_ACC_CLK,
    input  logic               acc_ff_rstn,
    input  logic               EFPGA_MATHB_CLK_EN,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_oper,
    input  logic [DATA_W-1:0]  in_coef,
    input  logic [CNT_W-1:0]   cfg_len,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_tc,
    input  logic               cfg_rnd,
    input  logic               cfg_sat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat,
    output logic               busy
);

    localparam int unsigned PW   = 2*DATA_W;
    localparam int unsigned SMAX = ACC_W - OUT_W;

    logic adv;
    logic accept;

    // beat counter and frame config held from the first beat
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               tc_q, rnd_q, sat_q;
    logic               first_beat;
    logic               last_beat;
    logic [CNT_W-1:0]   len_cur;

    // S1
    logic               s1_valid, s1_first, s1_last;
    logic [DATA_W-1:0]  s1_a, s1_b;
    logic [SHIFT_W-1:0] s1_shift;
    logic               s1_tc, s1_rnd, s1_sat;

    // S2
    logic               s2_valid, s2_first, s2_last;
    logic [ACC_W-1:0]   s2_prod;
    logic [SHIFT_W-1:0] s2_shift;
    logic               s2_tc, s2_rnd, s2_sat;

    // S3
    logic [ACC_W-1:0]   acc;

    logic signed [PW-1:0] prod_s;
    logic [PW-1:0]        prod_u;
    logic [ACC_W-1:0]     prod_ext;

    logic [31:0]             sh_c;
    logic [ACC_W-1:0]        seed;
    logic [ACC_W-1:0]        sum;
    logic [ACC_W-1:0]        hi_u;
    logic signed [ACC_W-1:0] hi_s;
    logic                    ovf;
    logic                    sat_hit;
    logic [OUT_W-1:0]        win;
    logic [OUT_W-1:0]        satval;
    logic [OUT_W-1:0]        fmt;

    assign adv      = EFPGA_MATHB_CLK_EN & (~out_valid | out_ready);
    assign in_ready = adv & ~flush;
    assign accept   = in_valid & in_ready;
    assign busy     = (cnt != '0) | s1_valid | s2_valid | out_valid;

    assign first_beat = (cnt == '0);
    assign len_cur    = first_beat ? cfg_len : len_q;
    assign last_beat  = (len_cur == '0) ? 1'b1 : (cnt == len_cur - CNT_W'(1));

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            cnt      <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            tc_q     <= 1'b0;
            rnd_q    <= 1'b0;
            sat_q    <= 1'b0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_shift <= '0;
            s1_tc    <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_sat   <= 1'b0;
        end else if (flush) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                cnt      <= last_beat ? '0 : cnt + CNT_W'(1);
                s1_a     <= in_oper;
                s1_b     <= in_coef;
                s1_first <= first_beat;
                s1_last  <= last_beat;
                s1_shift <= first_beat ? cfg_shift : shift_q;
                s1_tc    <= first_beat ? cfg_tc    : tc_q;
                s1_rnd   <= first_beat ? cfg_rnd   : rnd_q;
                s1_sat   <= first_beat ? cfg_sat   : sat_q;
                if (first_beat) begin
                    len_q   <= cfg_len;
                    shift_q <= cfg_shift;
                    tc_q    <= cfg_tc;
                    rnd_q   <= cfg_rnd;
                    sat_q   <= cfg_sat;
                end
            end
        end
    end

    // size casts of the signed product sign-extend; unsigned ones zero-extend
    assign prod_s   = PW'($signed(s1_a)) * PW'($signed(s1_b));
    assign prod_u   = PW'(s1_a) * PW'(s1_b);
    assign prod_ext = s1_tc ? ACC_W'(prod_s) : ACC_W'(prod_u);

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
            s2_shift <= '0;
            s2_tc    <= 1'b0;
            s2_rnd   <= 1'b0;
            s2_sat   <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_prod  <= prod_ext;
            s2_shift <= s1_shift;
            s2_tc    <= s1_tc;
            s2_rnd   <= s1_rnd;
            s2_sat   <= s1_sat;
        end
    end

    always_comb begin
        sh_c = 32'(s2_shift);
        if (sh_c > SMAX) sh_c = SMAX;
        seed = (s2_rnd && sh_c != 0) ? (ACC_W'(1) << (sh_c - 1)) : '0;
        sum  = (s2_first ? seed : acc) + s2_prod;
        win  = OUT_W'(sum >> sh_c);
        // bits above the output window must be zero (unsigned) or copies of the window MSB (signed)
        hi_u = sum >> (sh_c + OUT_W);
        hi_s = $signed(sum) >>> (sh_c + OUT_W - 1);
        if (s2_tc) begin
            ovf    = !((hi_s == '0) || (hi_s == '1));
            satval = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            ovf    = (hi_u != '0);
            satval = '1;
        end
        sat_hit = s2_sat & ovf;
        fmt     = sat_hit ? satval : win;
    end

    always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (flush) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid) begin
                acc <= sum;
                if (s2_last) begin
                    out_data <= fmt;
                    out_sat  <= sat_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_stream.sv
// Directed bench for mac_acc_stream: hand-computed frame results, stall, freeze,
// flush and async reset behaviour.
module tb_mac_acc_stream;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_oper, in_coef;
    logic [7:0] cfg_len;
    logic [5:0] cfg_shift;
    logic       cfg_tc, cfg_rnd, cfg_sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mac_acc_stream dut (
        .MAC_ACC_CLK        (clk),
        .acc_ff_rstn        (rstn),
        .EFPGA_MATHB_CLK_EN (en),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_oper            (in_oper),
        .in_coef            (in_coef),
        .cfg_len            (cfg_len),
        .cfg_shift          (cfg_shift),
        .cfg_tc             (cfg_tc),
        .cfg_rnd            (cfg_rnd),
        .cfg_sat            (cfg_sat),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_sat            (out_sat),
        .busy               (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] len, input logic [5:0] sh,
                           input logic tc, input logic rnd, input logic sat);
        cfg_len = len; cfg_shift = sh; cfg_tc = tc; cfg_rnd = rnd; cfg_sat = sat;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_oper = a; in_coef = b;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) check("beat_accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] ed, input logic es);
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk); n++;
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_data"}, {24'b0, out_data}, {24'b0, ed});
        check({tag, "_sat"}, {31'b0, out_sat}, {31'b0, es});
        @(posedge clk); #1;
    endtask

    initial begin
        int tx;
        int rx;
        rstn = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_oper = '0; in_coef = '0; out_ready = 1'b1;
        set_cfg(8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_out_sat", {31'b0, out_sat}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // unsigned len=4: sum 0xFED9
        set_cfg(8'd4, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'd10, 8'd20); send_beat(8'd3, 8'd5);
        send_beat(8'd255, 8'd255); send_beat(8'd1, 8'd1);
        expect_result("t1_trunc", 8'hD9, 1'b0);

        // same frame saturating; cfg_sat dropped mid-frame must be ignored
        set_cfg(8'd4, 6'd0, 1'b0, 1'b0, 1'b1);
        send_beat(8'd10, 8'd20);
        cfg_sat = 1'b0;
        send_beat(8'd3, 8'd5); send_beat(8'd255, 8'd255); send_beat(8'd1, 8'd1);
        expect_result("t1_sat", 8'hFF, 1'b1);

        // signed len=2
        set_cfg(8'd2, 6'd0, 1'b1, 1'b0, 1'b1);
        send_beat(8'hFD, 8'd4); send_beat(8'd2, 8'd1);
        expect_result("t2_neg", 8'hF6, 1'b0);
        send_beat(8'd100, 8'd100); send_beat(8'd100, 8'd100);
        expect_result("t2_sat", 8'h7F, 1'b1);

        // shift 4 with and without rounding
        set_cfg(8'd1, 6'd4, 1'b0, 1'b1, 1'b0);
        send_beat(8'd5, 8'd5);
        expect_result("t3_rnd", 8'h02, 1'b0);
        set_cfg(8'd1, 6'd4, 1'b0, 1'b0, 1'b0);
        send_beat(8'd5, 8'd5);
        expect_result("t3_trunc", 8'h01, 1'b0);

        // len=0 acts as len=1
        set_cfg(8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'd7, 8'd7);
        expect_result("len0", 8'h31, 1'b0);
        @(negedge clk);
        check("len0_idle_busy", {31'b0, busy}, 32'd0);

        // shift 63 clamps to 16: (2^15 + 65025) >> 16 = 1
        set_cfg(8'd1, 6'd63, 1'b0, 1'b1, 1'b0);
        send_beat(8'd255, 8'd255);
        expect_result("clamp", 8'h01, 1'b0);

        // 8 streamed len=1 frames with a 5-cycle consumer stall
        set_cfg(8'd1, 6'd0, 1'b0, 1'b0, 1'b0);
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid  = (tx < 8);
            in_oper   = 8'(tx + 1);
            in_coef   = 8'd3;
            #1;
            if (!out_ready) begin
                check("t4_stall_in_ready", {31'b0, in_ready}, 32'd0);
                check("t4_stall_out_valid", {31'b0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                check("t4_data", {24'b0, out_data}, 32'(3 * (rx + 1)));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        check("t4_rx_count", 32'(rx), 32'd8);
        check("t4_tx_count", 32'(tx), 32'd8);

        // clock-enable freeze mid-frame
        set_cfg(8'd4, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'd10, 8'd20); send_beat(8'd3, 8'd5);
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; in_oper = 8'd255; in_coef = 8'd255;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_frz_in_ready", {31'b0, in_ready}, 32'd0);
            check("t5_frz_busy", {31'b0, busy}, 32'd1);
            check("t5_frz_out_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; en = 1'b1;
        send_beat(8'd255, 8'd255); send_beat(8'd1, 8'd1);
        expect_result("t5_freeze", 8'hD9, 1'b0);

        // flush after 2nd beat of a len=4 frame
        set_cfg(8'd4, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'd10, 8'd20); send_beat(8'd3, 8'd5);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_oper = 8'd9; in_coef = 8'd9;
        #1;
        check("t6_flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("t6_flush_busy", {31'b0, busy}, 32'd0);
        set_cfg(8'd1, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'd2, 8'd3);
        expect_result("t6_flush", 8'h06, 1'b0);

        // async reset after 2nd beat
        set_cfg(8'd4, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'd10, 8'd20); send_beat(8'd3, 8'd5);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
        #2;
        rstn = 1'b1;
        set_cfg(8'd1, 6'd0, 1'b0, 1'b0, 1'b0);
        send_beat(8'd2, 8'd3);
        expect_result("t6_rst", 8'h06, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
